// File: rtl/rw_stream_adapter.sv
// rw_stream_adapter
//   Bridges a byte-wide device (one input byte, one output byte valid every
//   cycle) onto two ready/valid host channels. A start request opens a capture
//   session: the first SKIP device output bytes are discarded (PRIME), then
//   every device output byte is captured into a FIFO (RUN) that the host drains
//   through the rx channel. Host bytes on the tx channel are accepted only in
//   RUN and are held on dev_in until the next accepted byte.
//
// Parameters
//   DEPTH     capture FIFO depth in bytes, power of two, 2..64
//   SKIP      device output bytes discarded after each start, 0..15
//
// Ports
//   clk       sole clock, rising edge
//   rst       asynchronous active-high reset
//   start     single-cycle session start request
//   stop      single-cycle session stop request (wins over start)
//   dev_in    byte driven into the device
//   dev_out   byte sampled from the device every cycle
//   tx_valid / tx_ready / tx_data   host-to-device channel
//   rx_valid / rx_ready / rx_data   device-to-host channel
//   busy      high whenever a session is active (state not IDLE)
//   overflow  sticky: a captured byte was dropped because the FIFO was full
//   ovf_count saturating count of dropped bytes (only with the macro below)
//
// Optional feature macro: RW_ADAPTER_OVF_COUNT_EN adds the ovf_count output.
//
// States
//   IDLE  | no session; start opens one
//   PRIME | discarding the first SKIP device bytes
//   RUN   | capturing device bytes, accepting tx bytes

module rw_stream_adapter #(
  parameter int DEPTH = 8,
  parameter int SKIP  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  output logic [7:0] dev_in,
  input  logic [7:0] dev_out,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       overflow
`ifdef RW_ADAPTER_OVF_COUNT_EN
  ,
  output logic [7:0] ovf_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] SKIP_M1 = (SKIP > 0) ? 4'(SKIP - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [3:0]    skip_cnt;
  logic          start_ok;

  logic [AW:0]   wr_ptr, rd_ptr;
  logic [7:0]    mem [DEPTH];
  logic          empty, full;
  logic          push_req, push, pop, drop;

  // A start is only honoured from IDLE and never alongside stop.
  assign start_ok = start & ~stop & (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_ok) state_nxt = (SKIP == 0) ? RUN : PRIME;
      end
      PRIME: begin
        if (stop)                 state_nxt = IDLE;
        else if (skip_cnt == 4'd0) state_nxt = RUN;
      end
      RUN: begin
        if (stop) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Down-counter loaded with SKIP-1 so PRIME lasts exactly SKIP cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skip_cnt <= 4'd0;
    end else if (start_ok) begin
      skip_cnt <= SKIP_M1;
    end else if (state == PRIME && skip_cnt != 4'd0) begin
      skip_cnt <= skip_cnt - 4'd1;
    end
  end

  assign busy     = (state != IDLE);
  assign tx_ready = (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       dev_in <= 8'h00;
    else if (tx_valid && tx_ready) dev_in <= tx_data;
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_req = (state == RUN);
  assign pop      = rx_ready & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  assign rx_valid = ~empty;
  assign rx_data  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= dev_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           overflow <= 1'b0;
    else if (start_ok) overflow <= 1'b0;
    else if (drop)     overflow <= 1'b1;
  end

`ifdef RW_ADAPTER_OVF_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             ovf_count <= 8'h00;
    else if (start_ok)                   ovf_count <= 8'h00;
    else if (drop && ovf_count != 8'hFF) ovf_count <= ovf_count + 8'h01;
  end
`endif

endmodule

// File: tb/tb_rw_stream_adapter.sv
module tb_rw_stream_adapter;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop;
  logic [7:0] dev_in, dev_out;
  logic       tx_valid, tx_ready;
  logic [7:0] tx_data;
  logic       rx_valid, rx_ready;
  logic [7:0] rx_data;
  logic       busy, overflow;
`ifdef RW_ADAPTER_OVF_COUNT_EN
  logic [7:0] ovf_count;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rw_stream_adapter #(.DEPTH(8), .SKIP(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .dev_in   (dev_in),
    .dev_out  (dev_out),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .rx_data  (rx_data),
    .busy     (busy),
    .overflow (overflow)
`ifdef RW_ADAPTER_OVF_COUNT_EN
    ,
    .ovf_count(ovf_count)
`endif
  );

  typedef struct {
    logic       start;
    logic       stop;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic [7:0] dev_out;
    logic       rx_ready;
    logic       busy;
    logic       tx_ready;
    logic [7:0] dev_in;
    logic       rx_valid;
    logic       chk_data;
    logic [7:0] rx_data;
    logic       ovf;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; stop = 0; tx_valid = 0; tx_data = 8'h00;
    dev_out = 8'h00; rx_ready = 0;
  endtask

  initial begin
    //           st st tv txd    dout   rr  bsy txr devin  rxv cd rxd    ovf
    vt[0]  = '{1, 0, 0, 8'h00, 8'h00, 0,  0, 0, 8'h00, 0, 0, 8'h00, 0};
    vt[1]  = '{0, 0, 0, 8'h00, 8'h10, 0,  1, 0, 8'h00, 0, 0, 8'h00, 0};
    vt[2]  = '{0, 0, 0, 8'h00, 8'h11, 0,  1, 1, 8'h00, 0, 0, 8'h00, 0};
    vt[3]  = '{0, 0, 0, 8'h00, 8'h12, 0,  1, 1, 8'h00, 1, 1, 8'h11, 0};
    vt[4]  = '{0, 1, 1, 8'hA5, 8'h13, 0,  1, 1, 8'h00, 1, 1, 8'h11, 0};
    vt[5]  = '{0, 0, 0, 8'h00, 8'h00, 1,  0, 0, 8'hA5, 1, 1, 8'h11, 0};
    vt[6]  = '{0, 0, 0, 8'h00, 8'h00, 1,  0, 0, 8'hA5, 1, 1, 8'h12, 0};
    vt[7]  = '{0, 0, 0, 8'h00, 8'h00, 1,  0, 0, 8'hA5, 1, 1, 8'h13, 0};
    vt[8]  = '{0, 0, 0, 8'h00, 8'h00, 1,  0, 0, 8'hA5, 0, 0, 8'h00, 0};
    vt[9]  = '{1, 1, 0, 8'h00, 8'h00, 0,  0, 0, 8'hA5, 0, 0, 8'h00, 0};
    vt[10] = '{0, 0, 0, 8'h00, 8'h00, 0,  0, 0, 8'hA5, 0, 0, 8'h00, 0};

    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_tx_ready", {7'd0, tx_ready}, 8'd0);
    chk("rst_rx_valid", {7'd0, rx_valid}, 8'd0);
    chk("rst_dev_in", dev_in, 8'h00);
    chk("rst_overflow", {7'd0, overflow}, 8'd0);
`ifdef RW_ADAPTER_OVF_COUNT_EN
    chk("rst_ovf_count", ovf_count, 8'h00);
`endif
    rst = 0;
    tick();

    // Session with skip, tx transfer, stop, drain, start+stop collision.
    for (int i = 0; i < 11; i++) begin
      start = vt[i].start; stop = vt[i].stop;
      tx_valid = vt[i].tx_valid; tx_data = vt[i].tx_data;
      dev_out = vt[i].dev_out; rx_ready = vt[i].rx_ready;
      #1;
      chk($sformatf("v%0d_busy", i), {7'd0, busy}, {7'd0, vt[i].busy});
      chk($sformatf("v%0d_tx_ready", i), {7'd0, tx_ready}, {7'd0, vt[i].tx_ready});
      chk($sformatf("v%0d_dev_in", i), dev_in, vt[i].dev_in);
      chk($sformatf("v%0d_rx_valid", i), {7'd0, rx_valid}, {7'd0, vt[i].rx_valid});
      if (vt[i].chk_data)
        chk($sformatf("v%0d_rx_data", i), rx_data, vt[i].rx_data);
      chk($sformatf("v%0d_overflow", i), {7'd0, overflow}, {7'd0, vt[i].ovf});
      tick();
    end
    idle_inputs();

    // Fill past capacity: 10 RUN cycles with no reads into an 8-deep FIFO.
    start = 1; tick(); start = 0;
    dev_out = 8'hFF; tick();
    for (int i = 0; i < 10; i++) begin
      dev_out = 8'h30 + 8'(i);
      tick();
      if (i == 7) chk("full_no_drop_yet", {7'd0, overflow}, 8'd0);
    end
    chk("ovf_set", {7'd0, overflow}, 8'd1);
    chk("ovf_head", rx_data, 8'h30);
`ifdef RW_ADAPTER_OVF_COUNT_EN
    chk("ovf_count_2", ovf_count, 8'd2);
`endif

    // Full with continuous reads: one byte per cycle, no further drops.
    for (int i = 0; i < 12; i++) begin
      dev_out = 8'h40 + 8'(i);
      rx_ready = 1;
      #1;
      chk($sformatf("full_rd%0d_valid", i), {7'd0, rx_valid}, 8'd1);
      chk($sformatf("full_rd%0d_data", i), rx_data,
          (i < 8) ? 8'h30 + 8'(i) : 8'h40 + 8'(i - 8));
      tick();
    end
    chk("ovf_hold", {7'd0, overflow}, 8'd1);
`ifdef RW_ADAPTER_OVF_COUNT_EN
    chk("ovf_count_hold", ovf_count, 8'd2);
`endif

    // Stop in RUN: IDLE on next edge, FIFO keeps draining.
    stop = 1; dev_out = 8'h4C; #1;
    chk("stop_busy_before", {7'd0, busy}, 8'd1);
    chk("stop_data", rx_data, 8'h44);
    tick();
    stop = 0;
    chk("stop_busy_after", {7'd0, busy}, 8'd0);
    chk("stop_rx_valid", {7'd0, rx_valid}, 8'd1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d", i), rx_data, 8'h45 + 8'(i));
      tick();
    end
    chk("drained_empty", {7'd0, rx_valid}, 8'd0);
    chk("drain_dev_in", dev_in, 8'hA5);

    // New start clears overflow; then reset mid-session with 5 bytes held.
    rx_ready = 0;
    start = 1; tick(); start = 0;
    chk("start_clr_ovf", {7'd0, overflow}, 8'd0);
`ifdef RW_ADAPTER_OVF_COUNT_EN
    chk("start_clr_cnt", ovf_count, 8'd0);
`endif
    chk("start_busy", {7'd0, busy}, 8'd1);
    tick();
    for (int i = 0; i < 5; i++) begin
      tx_valid = (i == 0); tx_data = 8'h5A;
      dev_out = 8'h50 + 8'(i);
      tick();
    end
    tx_valid = 0;
    chk("pre_rst_valid", {7'd0, rx_valid}, 8'd1);
    chk("pre_rst_dev_in", dev_in, 8'h5A);
    chk("pre_rst_data", rx_data, 8'h50);
    #2 rst = 1;
    #1;
    chk("mid_rst_valid", {7'd0, rx_valid}, 8'd0);
    chk("mid_rst_busy", {7'd0, busy}, 8'd0);
    chk("mid_rst_dev_in", dev_in, 8'h00);
    chk("mid_rst_tx_ready", {7'd0, tx_ready}, 8'd0);
    tick();
    rst = 0;
    tick();
    chk("post_rst_valid", {7'd0, rx_valid}, 8'd0);
    chk("post_rst_busy", {7'd0, busy}, 8'd0);
    chk("post_rst_dev_in", dev_in, 8'h00);
    start = 1; tick(); start = 0;
    chk("post_rst_start", {7'd0, busy}, 8'd1);
    tick();
    chk("post_rst_run", {7'd0, tx_ready}, 8'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rw_stream_adapter.md
RW_STREAM_ADAPTER -- requirements
Module: rw_stream_adapter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, capture FIFO depth in bytes (power of two, 2..64).
REQ-002 The block SHALL have parameter SKIP, default 1, number of device output bytes discarded after each start (0..15).
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port start  input  1  single-cycle request to begin a capture session.
REQ-006 The block SHALL have port stop  input  1  single-cycle request to end the session.
REQ-007 The block SHALL have port dev_in  output  8  byte driven into the device's __in0.
REQ-008 The block SHALL have port dev_out  input  8  byte sampled from the device's __out0, valid every cycle.
REQ-009 The block SHALL have ports tx_valid, tx_ready and tx_data  input/output/input  1/1/8  host-to-device ready/valid channel.
REQ-010 The block SHALL have ports rx_valid, rx_ready and rx_data  output/input/output  1/1/8  device-to-host ready/valid channel.
REQ-011 The block SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 The block SHALL have port overflow  output  1  sticky flag: a captured byte was dropped.

Function
REQ-013 The FSM SHALL have states IDLE, PRIME and RUN.
REQ-014 In IDLE, start SHALL move the FSM to PRIME, or to RUN when SKIP=0.
REQ-015 In PRIME, one dev_out byte SHALL be discarded per cycle; after SKIP cycles the FSM SHALL move to RUN.
REQ-016 In PRIME or RUN, stop SHALL move the FSM to IDLE on the next edge; FIFO contents SHALL be retained.
REQ-017 When start and stop are asserted in the same cycle, stop SHALL win; start while not in IDLE SHALL be ignored.
REQ-018 tx_ready SHALL equal 1 exactly when the state is RUN; a transfer is tx_valid & tx_ready.
REQ-019 On a tx transfer, dev_in SHALL equal tx_data from the next cycle and hold it until the next transfer (one-cycle latency).
REQ-020 Without a transfer, dev_in SHALL hold its last value, including across IDLE.
REQ-021 In RUN, dev_out SHALL be pushed into the FIFO every cycle.
REQ-022 rx_valid SHALL equal FIFO not-empty; rx_data SHALL be the oldest entry; rx_valid & rx_ready SHALL pop it.
REQ-023 A byte pushed at edge n SHALL be visible on rx_data no earlier than cycle n+1.
REQ-024 FIFO full, push without pop: the byte SHALL be dropped, overflow SHALL set and the FIFO SHALL be unchanged.
REQ-025 FIFO full, push with pop in the same cycle: the pop and push SHALL both occur, with no drop.
REQ-026 FIFO empty: a pop request SHALL be ignored; rx_data is don't-care while rx_valid=0.
REQ-027 Read and write pointers SHALL be log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full and empty are decoded from the MSB and the remaining bits.
REQ-028 overflow SHALL clear only on reset or on a start accepted in IDLE.

Reset
REQ-029 During rst=1 the block SHALL hold state IDLE, FIFO empty, dev_in=8'h00, tx_ready=0, rx_valid=0, busy=0, overflow=0 and the PRIME counter at 0.
REQ-030 rst asserted mid-session SHALL immediately abort the session and discard all FIFO contents; the first edge after release SHALL operate from the reset state.

Configuration
REQ-031 With macro RW_ADAPTER_OVF_COUNT_EN defined, the block SHALL add output ovf_count (8 bits), reset to 0.
REQ-032 ovf_count SHALL increment once per dropped byte, saturate at 8'hFF, and clear together with overflow.
REQ-033 Without RW_ADAPTER_OVF_COUNT_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-034 Reset, then start with SKIP=1 and dev_out=8'h10,11,12,13 on successive cycles -> rx delivers 8'h11,12,13 in order; 8'h10 is discarded.
REQ-035 RUN with tx_valid=1 and tx_data=8'hA5 for one cycle -> dev_in=8'hA5 from the next cycle, then held while tx_valid=0.
REQ-036 DEPTH=8, rx_ready=0 for 10 RUN cycles -> 8 bytes held, overflow=1, ovf_count=2 (macro on); the first 8 bytes are read back intact.
REQ-037 FIFO full with rx_ready=1 continuously -> no further drops, overflow unchanged, and the rx output stream is one byte per cycle.
REQ-038 start and stop asserted together in IDLE -> remains IDLE, busy=0; a later stop in RUN -> IDLE next edge with the FIFO still draining.
REQ-039 rst pulse while the FIFO holds 5 bytes in RUN -> rx_valid=0, busy=0, dev_in=8'h00 while rst=1 and after release.
